// File: rtl/ad1_fft_pkg.sv
// ad1_fft_pkg: shared constants, twiddle ROM and output saturation for the AD1 capture/spectrum block
package ad1_fft_pkg;
  localparam int SCLK_HALF = 3;
  localparam int QUIET = 12;
  localparam int N = 64;
  localparam int LOG2N = $clog2(N);
  localparam int DW = 12;
  localparam int OW = 24;
  localparam int AW = 47;
  localparam int ACC_W = OW + LOG2N;
  typedef enum logic {S_QUIET, S_FRAME} seq_t;
  typedef logic signed [DW-1:0] smp_t;
  // Quarter wave of round(2047*cos(2*pi*i/64)); the other quadrants follow by symmetry, which ties N to 64
  localparam smp_t QTAB [17] = '{
    12'sd2047, 12'sd2037, 12'sd2008, 12'sd1959, 12'sd1891, 12'sd1805, 12'sd1702, 12'sd1582, 12'sd1447,
    12'sd1299, 12'sd1137, 12'sd965, 12'sd783, 12'sd594, 12'sd399, 12'sd201, 12'sd0};
  function automatic smp_t cos_rom(input logic [LOG2N-1:0] i);
    smp_t q;
    q = QTAB[i[4] ? 5'd16 - {1'b0, i[3:0]} : {1'b0, i[3:0]}];
    return (i[5] ^ i[4]) ? -q : q;
  endfunction
  function automatic logic signed [OW-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
    logic signed [OW-1:0] t;
    t = a[ACC_W-1:LOG2N];
    return (t == {1'b1, {(OW-1){1'b0}}}) ? {1'b1, {(OW-2){1'b0}}, 1'b1} : t;
  endfunction
endpackage

// File: rtl/ad1_dft_channel.sv
// ad1_dft_channel: ping-pong sample buffer feeding a one-MAC-per-clock DFT with scaled bins and power
module ad1_dft_channel
  import ad1_fft_pkg::*;
(
  input  logic          clk,
  input  logic          aresetn,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [OW-1:0] fft_real,
  output logic [OW-1:0] fft_imag,
  output logic [AW-1:0] amp,
  output logic          fft_out_valid
);
  smp_t mem [2][N];
  smp_t x, xs;
  logic wr_bank, rd_bank, busy, v1;
  logic [LOG2N-1:0] wr_idx, k, n, tw;
  logic signed [2*DW-1:0] p_re, p_im;
  logic signed [ACC_W-1:0] re_acc, im_acc, re_sum, im_sum;
  logic signed [OW-1:0] re1, im1;
  logic signed [2*OW-1:0] re_sq, im_sq;
  always_comb begin
    x = {~d[DW-1], d[DW-2:0]};
    xs = mem[rd_bank][n];
    tw = k * n;
    p_re = (2*DW)'(xs) * (2*DW)'(cos_rom(tw));
    p_im = (2*DW)'(xs) * (2*DW)'(cos_rom(tw - LOG2N'(N / 4)));
    re_sum = (n == '0 ? '0 : re_acc) + ACC_W'(p_re);
    im_sum = (n == '0 ? '0 : im_acc) - ACC_W'(p_im);
    re_sq = (2*OW)'(re1) * (2*OW)'(re1);
    im_sq = (2*OW)'(im1) * (2*OW)'(im1);
  end
  always_ff @(posedge clk)
    if (we) mem[wr_bank][wr_idx] <= x;
  // A block that fills while the MAC is busy is dropped by refilling the same bank
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx <= '0;
      busy <= 1'b0;
      k <= '0;
      n <= '0;
      re_acc <= '0;
      im_acc <= '0;
      re1 <= '0;
      im1 <= '0;
      v1 <= 1'b0;
      fft_real <= '0;
      fft_imag <= '0;
      amp <= '0;
      fft_out_valid <= 1'b0;
    end else begin
      v1 <= busy && n == LOG2N'(N - 1);
      fft_out_valid <= v1;
      if (busy) begin
        re_acc <= re_sum;
        im_acc <= im_sum;
        n <= n + 1'b1;
        if (n == LOG2N'(N - 1)) begin
          re1 <= scale_sat(re_sum);
          im1 <= scale_sat(im_sum);
          k <= k + 1'b1;
          busy <= k != LOG2N'(N - 1);
        end
      end
      if (v1) begin
        fft_real <= re1;
        fft_imag <= im1;
        amp <= AW'(re_sq + im_sq);
      end
      if (we) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == LOG2N'(N - 1) && !busy) begin
          busy <= 1'b1;
          rd_bank <= wr_bank;
          wr_bank <= ~wr_bank;
          k <= '0;
          n <= '0;
        end
      end
    end
endmodule

// File: rtl/ad1_fft_top.sv
// ad1_fft_top: AD1 dual-ADC frame sequencer and deserialiser feeding two lockstep DFT channels
module ad1_fft_top
  import ad1_fft_pkg::*;
(
  input  logic          clk,
  input  logic          aresetn,
  input  logic          ADC_sdata0,
  input  logic          ADC_sdata1,
  output logic          ADC_sclk,
  output logic          ADC_csn,
  output logic [DW-1:0] data0,
  output logic [DW-1:0] data1,
  output logic [OW-1:0] fft_real1,
  output logic [OW-1:0] fft_real2,
  output logic [OW-1:0] fft_imag1,
  output logic [OW-1:0] fft_imag2,
  output logic [AW-1:0] amp1,
  output logic [AW-1:0] amp2,
  output logic          fft_out_valid1,
  output logic          fft_out_valid2
);
  localparam int PH_W = $clog2(2 * SCLK_HALF);
  localparam int Q_W = $clog2(QUIET);
  seq_t st, st_n;
  logic [PH_W-1:0] ph, ph_n;
  logic [3:0] bitn, bit_n;
  logic [Q_W-1:0] qc, qc_n;
  logic [DW-1:0] sr0, sr1;
  logic sample, done, done_q;
  always_comb begin
    st_n = st;
    ph_n = ph;
    bit_n = bitn;
    qc_n = qc;
    sample = 1'b0;
    done = 1'b0;
    if (st == S_QUIET) begin
      qc_n = qc + 1'b1;
      if (qc == Q_W'(QUIET - 1)) begin
        st_n = S_FRAME;
        qc_n = '0;
        ph_n = '0;
        bit_n = '0;
      end
    end else begin
      sample = ph == PH_W'(SCLK_HALF - 1);
      ph_n = ph == PH_W'(2 * SCLK_HALF - 1) ? '0 : ph + 1'b1;
      if (ph == PH_W'(2 * SCLK_HALF - 1)) begin
        bit_n = bitn + 1'b1;
        done = bitn == 4'd15;
        st_n = done ? S_QUIET : S_FRAME;
      end
    end
  end
  // Shift registers keep only the last 12 bits, so the four leading zeros fall out
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      st <= S_QUIET;
      ph <= '0;
      bitn <= '0;
      qc <= '0;
      ADC_csn <= 1'b1;
      ADC_sclk <= 1'b1;
      sr0 <= '0;
      sr1 <= '0;
      done_q <= 1'b0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      st <= st_n;
      ph <= ph_n;
      bitn <= bit_n;
      qc <= qc_n;
      ADC_csn <= st_n == S_QUIET;
      ADC_sclk <= st_n == S_QUIET || ph_n >= PH_W'(SCLK_HALF);
      if (sample) begin
        sr0 <= {sr0[DW-2:0], ADC_sdata0};
        sr1 <= {sr1[DW-2:0], ADC_sdata1};
      end
      done_q <= done;
      if (done_q) begin
        data0 <= sr0;
        data1 <= sr1;
      end
    end
  ad1_dft_channel u_ch0 (
    .clk(clk), .aresetn(aresetn), .we(done_q), .d(sr0),
    .fft_real(fft_real1), .fft_imag(fft_imag1), .amp(amp1), .fft_out_valid(fft_out_valid1));
  ad1_dft_channel u_ch1 (
    .clk(clk), .aresetn(aresetn), .we(done_q), .d(sr1),
    .fft_real(fft_real2), .fft_imag(fft_imag2), .amp(amp2), .fft_out_valid(fft_out_valid2));
endmodule

// File: tb/tb_ad1_fft_top.sv
// tb_ad1_fft_top: directed checks of ADC framing, capture, DC and tone spectra, and mid-frame reset
module tb_ad1_fft_top;
  localparam int NB = 64;
  logic clk = 1'b0, aresetn = 1'b0, ADC_sdata0 = 1'b1, ADC_sdata1 = 1'b0;
  logic ADC_sclk, ADC_csn, fft_out_valid1, fft_out_valid2;
  logic [11:0] data0, data1;
  logic [23:0] fft_real1, fft_real2, fft_imag1, fft_imag2;
  logic [46:0] amp1, amp2;
  int checks = 0, failures = 0;
  logic tone_mode = 1'b0;
  int tn = 0, bi = 0, nv = 0, vmis = 0;
  logic [15:0] w0 = 16'hFFFF;
  logic pc = 1'b1, ps = 1'b1;
  logic [11:0] tone [16];
  longint re_a [2][NB], im_a [2][NB], amp_a [2][NB];

  ad1_fft_top dut (
    .clk(clk), .aresetn(aresetn), .ADC_sdata0(ADC_sdata0), .ADC_sdata1(ADC_sdata1),
    .ADC_sclk(ADC_sclk), .ADC_csn(ADC_csn), .data0(data0), .data1(data1),
    .fft_real1(fft_real1), .fft_real2(fft_real2), .fft_imag1(fft_imag1), .fft_imag2(fft_imag2),
    .amp1(amp1), .amp2(amp2), .fft_out_valid1(fft_out_valid1), .fft_out_valid2(fft_out_valid2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // ADC model: word presented MSB first from csn fall, next bit after each sclk fall
  always @(negedge clk) begin
    if (!ADC_csn && pc) begin
      w0 = tone_mode ? {4'b0, tone[tn % 16]} : 16'hFFFF;
      tn++;
      bi = 15;
      ADC_sdata0 = w0[bi];
    end else if (!ADC_csn && !ADC_sclk && ps && bi > 0) begin
      bi--;
      ADC_sdata0 = w0[bi];
    end
    pc = ADC_csn;
    ps = ADC_sclk;
  end

  task automatic run_block(output int t_first);
    int cyc = 0;
    t_first = -1;
    nv = 0;
    vmis = 0;
    while (t_first < 0 && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (fft_out_valid1) t_first = cyc;
    end
    check("valid_seen", longint'(t_first >= 0), 1);
    if (t_first >= 0)
      for (int c = 0; c < 4200; c++) begin
        if (c > 0) @(negedge clk);
        if (fft_out_valid1 !== fft_out_valid2) vmis++;
        if (fft_out_valid1) begin
          if (nv < NB) begin
            re_a[0][nv] = $signed(fft_real1);
            im_a[0][nv] = $signed(fft_imag1);
            amp_a[0][nv] = amp1;
            re_a[1][nv] = $signed(fft_real2);
            im_a[1][nv] = $signed(fft_imag2);
            amp_a[1][nv] = amp2;
          end
          nv++;
        end
      end
  endtask

  initial begin
    int lo = 0, hi = 0, rises = 0, cyc = 0, t0 = 0;
    logic s;
    longint mx, mo, v;
    for (int i = 0; i < 16; i++)
      tone[i] = 12'($rtoi(2047.0 * $cos(2.0 * 3.14159265358979 * 4.0 * i / 64.0) + 2048.5));
    repeat (3) @(negedge clk);
    check("rst_csn", ADC_csn, 1);
    check("rst_sclk", ADC_sclk, 1);
    check("rst_data0", data0, 0);
    check("rst_real1", fft_real1, 0);
    check("rst_amp1", amp1, 0);
    check("rst_valid1", fft_out_valid1, 0);
    aresetn = 1'b1;
    while (ADC_csn && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("csn_fall", ADC_csn, 0);
    s = ADC_sclk;
    while (!ADC_csn && lo < 500) begin
      lo++;
      @(negedge clk);
      if (ADC_sclk && !s) rises++;
      s = ADC_sclk;
    end
    while (ADC_csn && hi < 500) begin
      hi++;
      @(negedge clk);
    end
    check("csn_low_clks", lo, 96);
    check("sclk_rises", rises, 16);
    check("csn_high_clks", hi, 12);
    check("data0_const", data0, 12'hFFF);
    check("data1_const", data1, 12'h000);

    run_block(t0);
    check("dc_bins", nv, NB);
    check("dc_valid_lockstep", vmis, 0);
    check("dc_real1_bin0", re_a[0][0], 4190209);
    check("dc_real2_bin0", re_a[1][0], -4192256);
    check("dc_imag1_bin0", im_a[0][0], 0);
    check("dc_imag2_bin0", im_a[1][0], 0);
    check("dc_amp1_bin0", amp_a[0][0], 64'd17557851463681);
    check("dc_amp2_bin0", amp_a[1][0], 64'd17575010369536);
    mx = 0;
    for (int c = 0; c < 2; c++)
      for (int k = 1; k < NB; k++) begin
        v = re_a[c][k] < 0 ? -re_a[c][k] : re_a[c][k];
        if (v > mx) mx = v;
        v = im_a[c][k] < 0 ? -im_a[c][k] : im_a[c][k];
        if (v > mx) mx = v;
      end
    check("dc_leak_le_64", longint'(mx <= 64), 1);

    cyc = 0;
    while (!ADC_csn && cyc < 500) begin @(negedge clk); cyc++; end
    while (ADC_csn && cyc < 500) begin @(negedge clk); cyc++; end
    rises = 0;
    s = ADC_sclk;
    while (rises < 8 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (ADC_sclk && !s) rises++;
      s = ADC_sclk;
    end
    while (ADC_sclk && cyc < 1000) begin @(negedge clk); cyc++; end
    check("midrst_in_frame", ADC_csn, 0);
    #2;
    aresetn = 1'b0;
    tone_mode = 1'b1;
    tn = 0;
    #1;
    check("midrst_csn", ADC_csn, 1);
    check("midrst_sclk", ADC_sclk, 1);
    check("midrst_data0", data0, 0);
    check("midrst_valid1", fft_out_valid1, 0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;

    run_block(t0);
    check("fresh_block_wait", longint'(t0 > 6900), 1);
    check("tone_bins", nv, NB);
    check("tone_valid_lockstep", vmis, 0);
    mo = 0;
    for (int k = 0; k < NB; k++)
      if (k != 4 && k != 60 && amp_a[0][k] > mo) mo = amp_a[0][k];
    check("tone_peak_bin4", longint'(amp_a[0][4] > 64'd1000000000000 && amp_a[0][4] > 10000 * mo), 1);
    check("tone_peak_bin60", longint'(amp_a[0][60] > 64'd1000000000000 && amp_a[0][60] > 10000 * mo), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
